// File: rtl/shift_right_seq_if.sv
// shift_right_seq_if: request/result bundle for the multi-cycle right shifter
//   master drives start, flush, a, shamt, arith; slave returns busy, done, outS
interface shift_right_seq_if #(
    parameter int SIZE = 32
) ();
    localparam int SHW = $clog2(SIZE);
    logic            start;
    logic            flush;
    logic [SIZE-1:0] a;
    logic [SHW-1:0]  shamt;
    logic            arith;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] outS;
    modport master (output start, flush, a, shamt, arith, input busy, done, outS);
    modport slave (input start, flush, a, shamt, arith, output busy, done, outS);
endinterface

// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle logical/arithmetic right shifter, STEP bits per clock
//   clk, rst_n (async active-low); bus.slave: start/flush/a/shamt/arith in,
//   busy/done/outS out (all registered)
module shift_right_seq #(
    parameter int SIZE = 32,
    parameter int STEP = 1,
    localparam int SHW = $clog2(SIZE)
) (
    input logic              clk,
    input logic              rst_n,
    shift_right_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [SHW:0] STEP_W = (SHW + 1)'(STEP);
    state_t          state, state_nx;
    logic [SIZE-1:0] work, work_nx, out_q, out_nx, shifted;
    logic [SHW-1:0]  cnt, cnt_nx;
    logic [SHW:0]    k;
    logic [SIZE:0]   ext;
    logic            fill, fill_nx, busy_q, done_q;
    // prepending the fill bit lets a signed shift supply zero or sign fill alike
    always_comb begin
        k       = ({1'b0, cnt} < STEP_W) ? {1'b0, cnt} : STEP_W;
        ext     = $signed({fill, work}) >>> k;
        shifted = ext[SIZE-1:0];
    end
    always_comb begin
        state_nx = state;
        work_nx  = work;
        cnt_nx   = cnt;
        fill_nx  = fill;
        out_nx   = out_q;
        if (bus.flush) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    work_nx  = bus.a;
                    cnt_nx   = bus.shamt;
                    fill_nx  = bus.arith & bus.a[SIZE-1];
                    state_nx = (bus.shamt != '0) ? SHIFT : DONE;
                    out_nx   = (bus.shamt != '0) ? out_q : bus.a;
                end
                SHIFT: begin
                    work_nx  = shifted;
                    cnt_nx   = cnt - k[SHW-1:0];
                    state_nx = ({1'b0, cnt} == k) ? DONE : SHIFT;
                    out_nx   = ({1'b0, cnt} == k) ? shifted : out_q;
                end
                default: state_nx = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            fill   <= 1'b0;
            out_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            work   <= work_nx;
            cnt    <= cnt_nx;
            fill   <= fill_nx;
            out_q  <= out_nx;
            busy_q <= state_nx != IDLE;
            done_q <= state_nx == DONE;
        end
    end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.outS = out_q;
endmodule

// File: tb/tb_shift_right_seq.sv
// tb_shift_right_seq: directed checks of shift_right_seq with STEP=1 and STEP=4
module tb_shift_right_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    shift_right_seq_if #(.SIZE(32)) i1 ();
    shift_right_seq_if #(.SIZE(32)) i4 ();
    shift_right_seq #(.SIZE(32), .STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
    shift_right_seq #(.SIZE(32), .STEP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic drive(input bit s4, input logic st, input logic [31:0] av,
                         input logic [4:0] sh, input logic ar);
        if (s4) begin
            i4.start = st; i4.a = av; i4.shamt = sh; i4.arith = ar;
        end else begin
            i1.start = st; i1.a = av; i1.shamt = sh; i1.arith = ar;
        end
    endtask
    // issues one operation and returns cycles until done and cycles busy was high
    task automatic run(input bit s4, input logic [31:0] av, input logic [4:0] sh,
                       input logic ar, output int lat, output int bcnt);
        logic d;
        drive(s4, 1'b1, av, sh, ar);
        lat  = 0;
        bcnt = 0;
        do begin
            @(posedge clk);
            #1;
            if (lat == 0) drive(s4, 1'b0, av, sh, ar);
            lat++;
            bcnt += int'(s4 ? i4.busy : i1.busy);
            d = s4 ? i4.done : i1.done;
        end while (!d && lat < 100);
    endtask
    task automatic idle_chk(input string tag, input bit s4);
        @(posedge clk);
        #1;
        check({tag, "_busy_fall"}, {31'b0, s4 ? i4.busy : i1.busy}, 32'd0);
        check({tag, "_done_fall"}, {31'b0, s4 ? i4.done : i1.done}, 32'd0);
    endtask
    initial begin
        int lat, bcnt, dcnt;
        i1.flush = 1'b0;
        i4.flush = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, i1.busy}, 32'd0);
        check("rst_done", {31'b0, i1.done}, 32'd0);
        check("rst_outs", i1.outS, 32'd0);
        check("rst_outs4", i4.outS, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run(1'b0, 32'h8000_0000, 5'd4, 1'b0, lat, bcnt);
        check("srl4_lat", lat, 32'd5);
        check("srl4_busy", bcnt, 32'd5);
        check("srl4_outs", i1.outS, 32'h0800_0000);
        idle_chk("srl4", 1'b0);
        run(1'b0, 32'h8000_0000, 5'd31, 1'b1, lat, bcnt);
        check("sra31_lat", lat, 32'd32);
        check("sra31_outs", i1.outS, 32'hFFFF_FFFF);
        idle_chk("sra31", 1'b0);
        run(1'b0, 32'h8000_0000, 5'd31, 1'b0, lat, bcnt);
        check("srl31_lat", lat, 32'd32);
        check("srl31_outs", i1.outS, 32'h0000_0001);
        idle_chk("srl31", 1'b0);
        run(1'b0, 32'hDEAD_BEEF, 5'd0, 1'b1, lat, bcnt);
        check("zero_lat", lat, 32'd1);
        check("zero_outs", i1.outS, 32'hDEAD_BEEF);
        drive(1'b0, 1'b1, 32'h1234_5678, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        check("done_start_ign_busy", {31'b0, i1.busy}, 32'd0);
        check("done_start_ign_outs", i1.outS, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h1234_5678, 5'd0, 1'b0);
        check("idle_start_done", {31'b0, i1.done}, 32'd1);
        check("idle_start_outs", i1.outS, 32'h1234_5678);
        idle_chk("idle_start", 1'b0);
        run(1'b1, 32'hF000_0000, 5'd7, 1'b1, lat, bcnt);
        check("s4_sra7_lat", lat, 32'd3);
        check("s4_sra7_busy", bcnt, 32'd3);
        check("s4_sra7_outs", i4.outS, 32'hFFE0_0000);
        idle_chk("s4_sra7", 1'b1);
        run(1'b1, 32'h8000_0000, 5'd31, 1'b1, lat, bcnt);
        check("s4_sra31_lat", lat, 32'd9);
        check("s4_sra31_outs", i4.outS, 32'hFFFF_FFFF);
        idle_chk("s4_sra31", 1'b1);
        run(1'b1, 32'h1234_5678, 5'd5, 1'b0, lat, bcnt);
        check("s4_srl5_lat", lat, 32'd3);
        check("s4_srl5_outs", i4.outS, 32'h0091_A2B3);
        idle_chk("s4_srl5", 1'b1);
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 5'd20, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'hFFFF_FFFF, 5'd20, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("flush_pre_busy", {31'b0, i1.busy}, 32'd1);
        i1.flush = 1'b1;
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        i1.flush = 1'b0;
        drive(1'b0, 1'b0, 32'hFFFF_FFFF, 5'd0, 1'b0);
        check("flush_busy", {31'b0, i1.busy}, 32'd0);
        check("flush_done", {31'b0, i1.done}, 32'd0);
        dcnt = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            dcnt += int'(i1.done);
        end
        check("flush_no_done", dcnt, 32'd0);
        check("flush_outs", i1.outS, 32'h1234_5678);
        i1.flush = 1'b1;
        drive(1'b0, 1'b1, 32'hAAAA_AAAA, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        i1.flush = 1'b0;
        drive(1'b0, 1'b0, 32'hAAAA_AAAA, 5'd0, 1'b0);
        check("flush_start_busy", {31'b0, i1.busy}, 32'd0);
        check("flush_start_done", {31'b0, i1.done}, 32'd0);
        @(posedge clk);
        #1;
        check("flush_start_outs", i1.outS, 32'h1234_5678);
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 5'd20, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'hFFFF_FFFF, 5'd20, 1'b1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, i1.busy}, 32'd0);
        check("arst_done", {31'b0, i1.done}, 32'd0);
        check("arst_outs", i1.outS, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run(1'b0, 32'h0000_F000, 5'd8, 1'b1, lat, bcnt);
        check("post_rst_lat", lat, 32'd9);
        check("post_rst_outs", i1.outS, 32'h0000_00F0);
        idle_chk("post_rst", 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
